// File: rtl/lsu_if.sv
// Request/response bundle between a core pipeline and the load/store unit.
// The master drives requests; the slave (the LSU) answers with responses.
interface lsu_if #(
   parameter int WIDTH = 32
) ();
   logic             req_valid;
   logic             req_ready;
   logic             req_we;
   logic [2:0]       req_funct3;
   logic [WIDTH-1:0] req_addr;
   logic [WIDTH-1:0] req_wdata;
   logic             resp_valid;
   logic [WIDTH-1:0] resp_rdata;
   logic             resp_err;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/lsu.sv
// RV32I load/store unit: one request at a time, stores and errors answer in one
// cycle, loads in two (one-cycle RAM read latency), with lane steering and extension.
module lsu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   lsu_if.slave             bus,
   output logic [3:0]       ram_wr_en,
   output logic [WIDTH-1:0] ram_wr_addr,
   output logic [WIDTH-1:0] ram_wr_data,
   output logic             ram_rd_en,
   output logic [WIDTH-1:0] ram_rd_addr,
   input  logic [WIDTH-1:0] ram_rd_data
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WR   = 3'd1,
      S_RD   = 3'd2,
      S_RESP = 3'd3,
      S_ERR  = 3'd4
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   function automatic logic f_illegal(input logic we, input logic [2:0] funct3);
      logic bad;
      bad = 1'b0;
      if (we) begin
         bad = funct3[2] || (funct3 == 3'b011);
      end else begin
         case (funct3)
            3'b011, 3'b110, 3'b111: bad = 1'b1;
            default:                bad = 1'b0;
         endcase
      end
      return bad;
   endfunction

   // Only meaningful for legal encodings; funct3[1:0] gives the access size.
   function automatic logic f_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
      logic mis;
      mis = 1'b0;
      case (funct3[1:0])
         2'b01:   mis = addr_lo[0];
         2'b10:   mis = (addr_lo != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

   function automatic logic [3:0] f_wr_strobe(input logic [2:0] funct3, input logic [1:0] addr_lo);
      logic [3:0] strb;
      strb = 4'b0000;
      case (funct3)
         F3_B:    strb = 4'b0001 << addr_lo;
         F3_H:    strb = 4'b0011 << addr_lo;
         F3_W:    strb = 4'b1111;
         default: strb = 4'b0000;
      endcase
      return strb;
   endfunction

   // Replicate narrow store data across the word so every strobed lane sees it.
   function automatic logic [WIDTH-1:0] f_wr_data(input logic [2:0] funct3, input logic [WIDTH-1:0] wdata);
      logic [WIDTH-1:0] data;
      data = '0;
      case (funct3)
         F3_B:    data = {4{wdata[7:0]}};
         F3_H:    data = {2{wdata[15:0]}};
         F3_W:    data = wdata;
         default: data = '0;
      endcase
      return data;
   endfunction

   function automatic logic [WIDTH-1:0] f_load_data(input logic [2:0] funct3, input logic [1:0] addr_lo,
                                                   input logic [WIDTH-1:0] rdata);
      logic [7:0]       byte_v;
      logic [15:0]      half_v;
      logic [WIDTH-1:0] data;
      byte_v = 8'h00;
      half_v = 16'h0000;
      data   = '0;
      case (addr_lo)
         2'd0:    byte_v = rdata[7:0];
         2'd1:    byte_v = rdata[15:8];
         2'd2:    byte_v = rdata[23:16];
         2'd3:    byte_v = rdata[31:24];
         default: byte_v = 8'h00;
      endcase
      if (addr_lo[1]) begin
         half_v = rdata[31:16];
      end else begin
         half_v = rdata[15:0];
      end
      case (funct3)
         F3_B:    data = {{24{byte_v[7]}}, byte_v};
         F3_BU:   data = {24'h000000, byte_v};
         F3_H:    data = {{16{half_v[15]}}, half_v};
         F3_HU:   data = {16'h0000, half_v};
         F3_W:    data = rdata;
         default: data = '0;
      endcase
      return data;
   endfunction

   state_t           r_state;
   state_t           w_next;
   logic             r_we;
   logic [2:0]       r_funct3;
   logic [WIDTH-1:0] r_addr;
   logic [WIDTH-1:0] r_wdata;

   logic             w_accept;
   logic             w_bad;
   logic             w_req_ready;
   logic             w_resp_valid;
   logic [WIDTH-1:0] w_resp_rdata;
   logic             w_resp_err;
   logic [3:0]       w_wr_en;
   logic [WIDTH-1:0] w_wr_addr;
   logic [WIDTH-1:0] w_wr_data;
   logic             w_rd_en;
   logic [WIDTH-1:0] w_rd_addr;

   assign w_accept = (r_state == S_IDLE) && bus.req_valid;
   assign w_bad    = f_illegal(bus.req_we, bus.req_funct3) ||
                     f_misaligned(bus.req_funct3, bus.req_addr[1:0]);

   // State register and request capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_we     <= 1'b0;
         r_funct3 <= 3'b000;
         r_addr   <= '0;
         r_wdata  <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_we     <= bus.req_we;
            r_funct3 <= bus.req_funct3;
            r_addr   <= bus.req_addr;
            r_wdata  <= bus.req_wdata;
         end
      end
   end

   // Next-state and output decode; reset forces every output low immediately.
   always_comb begin
      w_next       = r_state;
      w_req_ready  = 1'b0;
      w_resp_valid = 1'b0;
      w_resp_rdata = '0;
      w_resp_err   = 1'b0;
      w_wr_en      = 4'b0000;
      w_wr_addr    = '0;
      w_wr_data    = '0;
      w_rd_en      = 1'b0;
      w_rd_addr    = '0;
      if (rst) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_req_ready = 1'b1;
               if (bus.req_valid) begin
                  if (w_bad) begin
                     w_next = S_ERR;
                  end else if (bus.req_we) begin
                     w_next = S_WR;
                  end else begin
                     w_next = S_RD;
                  end
               end else begin
                  w_next = S_IDLE;
               end
            end
            S_WR: begin
               // Strobes qualified by the captured direction so a load can never write.
               if (r_we) begin
                  w_wr_en   = f_wr_strobe(r_funct3, r_addr[1:0]);
                  w_wr_addr = r_addr;
                  w_wr_data = f_wr_data(r_funct3, r_wdata);
               end else begin
                  w_wr_en = 4'b0000;
               end
               w_resp_valid = 1'b1;
               w_next       = S_IDLE;
            end
            S_RD: begin
               if (!r_we) begin
                  w_rd_en   = 1'b1;
                  w_rd_addr = r_addr;
               end else begin
                  w_rd_en = 1'b0;
               end
               w_next = S_RESP;
            end
            S_RESP: begin
               w_resp_valid = 1'b1;
               w_resp_rdata = f_load_data(r_funct3, r_addr[1:0], ram_rd_data);
               w_next       = S_IDLE;
            end
            S_ERR: begin
               w_resp_valid = 1'b1;
               w_resp_err   = 1'b1;
               w_next       = S_IDLE;
            end
            default: begin
               w_next = S_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready  = w_req_ready;
   assign bus.resp_valid = w_resp_valid;
   assign bus.resp_rdata = w_resp_rdata;
   assign bus.resp_err   = w_resp_err;
   assign ram_wr_en      = w_wr_en;
   assign ram_wr_addr    = w_wr_addr;
   assign ram_wr_data    = w_wr_data;
   assign ram_rd_en      = w_rd_en;
   assign ram_rd_addr    = w_rd_addr;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: stores, loads, error cases, reset abort and a
// saturated request stream, each against hand-computed expectations.
module tb_lsu;

   logic        clk;
   logic        rst;
   logic [3:0]  ram_wr_en;
   logic [31:0] ram_wr_addr;
   logic [31:0] ram_wr_data;
   logic        ram_rd_en;
   logic [31:0] ram_rd_addr;
   logic [31:0] ram_rd_data;
   logic [31:0] tb_rd_word;

   int n_checks;
   int n_errors;

   lsu_if #(.WIDTH(32)) bus ();

   lsu #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .ram_wr_en   (ram_wr_en),
      .ram_wr_addr (ram_wr_addr),
      .ram_wr_data (ram_wr_data),
      .ram_rd_en   (ram_rd_en),
      .ram_rd_addr (ram_rd_addr),
      .ram_rd_data (ram_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM stand-in: read data appears one cycle after ram_rd_en, junk otherwise.
   always_ff @(posedge clk) begin
      if (ram_rd_en) ram_rd_data <= tb_rd_word;
      else           ram_rd_data <= 32'h0BAD0BAD;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      #1;
      check_eq("ready_idle", bus.req_ready, 1'b1);
      tick();
      bus.req_valid = 1'b0;
   endtask

   task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] exp_en, input logic [31:0] exp_data);
      issue(1'b1, f3, addr, wdata);
      check_eq({tag, "_wr_en"}, ram_wr_en, exp_en);
      check_eq({tag, "_wr_addr"}, ram_wr_addr, addr);
      check_eq({tag, "_wr_data"}, ram_wr_data, exp_data);
      check_eq({tag, "_resp_valid"}, bus.resp_valid, 1'b1);
      check_eq({tag, "_resp_err"}, bus.resp_err, 1'b0);
      check_eq({tag, "_rd_en"}, ram_rd_en, 1'b0);
      check_eq({tag, "_busy"}, bus.req_ready, 1'b0);
      tick();
      check_eq({tag, "_done_valid"}, bus.resp_valid, 1'b0);
      check_eq({tag, "_done_wr_en"}, ram_wr_en, 4'b0000);
   endtask

   task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] word, input logic [31:0] exp_rdata);
      tb_rd_word = word;
      issue(1'b0, f3, addr, 32'h0);
      check_eq({tag, "_rd_en"}, ram_rd_en, 1'b1);
      check_eq({tag, "_rd_addr"}, ram_rd_addr, addr);
      check_eq({tag, "_early_valid"}, bus.resp_valid, 1'b0);
      check_eq({tag, "_busy_rd"}, bus.req_ready, 1'b0);
      tick();
      check_eq({tag, "_resp_valid"}, bus.resp_valid, 1'b1);
      check_eq({tag, "_resp_err"}, bus.resp_err, 1'b0);
      check_eq({tag, "_rdata"}, bus.resp_rdata, exp_rdata);
      check_eq({tag, "_rd_en_off"}, ram_rd_en, 1'b0);
      check_eq({tag, "_busy_resp"}, bus.req_ready, 1'b0);
      tick();
      check_eq({tag, "_done_valid"}, bus.resp_valid, 1'b0);
   endtask

   task automatic do_err(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] addr);
      issue(we, f3, addr, 32'hFFFF_FFFF);
      check_eq({tag, "_resp_valid"}, bus.resp_valid, 1'b1);
      check_eq({tag, "_resp_err"}, bus.resp_err, 1'b1);
      check_eq({tag, "_rdata"}, bus.resp_rdata, 32'h0);
      check_eq({tag, "_wr_en"}, ram_wr_en, 4'b0000);
      check_eq({tag, "_rd_en"}, ram_rd_en, 1'b0);
      tick();
      check_eq({tag, "_done_valid"}, bus.resp_valid, 1'b0);
      check_eq({tag, "_done_wr_en"}, ram_wr_en, 4'b0000);
      check_eq({tag, "_done_rd_en"}, ram_rd_en, 1'b0);
      check_eq({tag, "_ready"}, bus.req_ready, 1'b1);
   endtask

   initial begin
      int phase;
      int kind;
      int k;
      int n_acc;
      int n_resp;
      logic [31:0] act_addr;
      logic [31:0] cur_addr;

      n_checks       = 0;
      n_errors       = 0;
      rst            = 1'b1;
      tb_rd_word     = 32'h0;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;

      tick();
      tick();
      tick();
      check_eq("rst_ready", bus.req_ready, 1'b0);
      check_eq("rst_resp_valid", bus.resp_valid, 1'b0);
      check_eq("rst_wr_en", ram_wr_en, 4'b0000);
      check_eq("rst_rd_en", ram_rd_en, 1'b0);
      check_eq("rst_wr_addr", ram_wr_addr, 32'h0);
      check_eq("rst_rd_addr", ram_rd_addr, 32'h0);
      rst = 1'b0;
      #1;
      check_eq("post_rst_ready", bus.req_ready, 1'b1);

      do_store("sw", 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
      do_store("sb", 3'b000, 32'h0000_0103, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
      do_store("sh", 3'b001, 32'h0000_0102, 32'h0000_1234, 4'b1100, 32'h1234_1234);
      do_store("sb0", 3'b000, 32'h0000_0100, 32'h1122_3344, 4'b0001, 32'h4444_4444);

      do_load("lb", 3'b000, 32'h0000_0201, 32'h0000_F000, 32'hFFFF_FFF0);
      do_load("lbu", 3'b100, 32'h0000_0201, 32'h0000_F000, 32'h0000_00F0);
      do_load("lhu", 3'b101, 32'h0000_0202, 32'h8001_0000, 32'h0000_8001);
      do_load("lh", 3'b001, 32'h0000_0202, 32'h8001_0000, 32'hFFFF_8001);
      do_load("lw", 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 32'hCAFE_F00D);

      do_err("lw_mis", 1'b0, 3'b010, 32'h0000_0102);
      do_err("sh_mis", 1'b1, 3'b001, 32'h0000_0101);
      do_err("ld_f011", 1'b0, 3'b011, 32'h0000_0100);
      do_err("st_f100", 1'b1, 3'b100, 32'h0000_0100);

      // Reset arrives while a load sits in RD: it must vanish without a trace.
      tb_rd_word = 32'h1357_9BDF;
      issue(1'b0, 3'b010, 32'h0000_0300, 32'h0);
      check_eq("abort_in_rd", ram_rd_en, 1'b1);
      rst = 1'b1;
      #1;
      check_eq("abort_rst_rd_en", ram_rd_en, 1'b0);
      check_eq("abort_rst_ready", bus.req_ready, 1'b0);
      tick();
      rst = 1'b0;
      #1;
      check_eq("abort_resp_valid", bus.resp_valid, 1'b0);
      check_eq("abort_rd_en", ram_rd_en, 1'b0);
      check_eq("abort_ready", bus.req_ready, 1'b1);
      tick();
      check_eq("abort_late_valid", bus.resp_valid, 1'b0);

      // Saturated stream of alternating SW/LW with req_valid never dropping.
      phase      = 0;
      kind       = 0;
      k          = 0;
      n_acc      = 0;
      n_resp     = 0;
      act_addr   = 32'h0;
      tb_rd_word = 32'h5A5A_C3C3;
      for (int cyc = 0; cyc < 20; cyc++) begin
         cur_addr       = 32'h0000_0400 + 32'(k * 4);
         bus.req_valid  = 1'b1;
         bus.req_we     = (kind == 0);
         bus.req_funct3 = 3'b010;
         bus.req_addr   = cur_addr;
         bus.req_wdata  = 32'hA000_0000 + 32'(k);
         #1;
         check_eq("stream_ready", bus.req_ready, (phase == 0) ? 1'b1 : 1'b0);
         tick();
         if (phase == 0) begin
            phase    = (kind == 0) ? 1 : 2;
            act_addr = cur_addr;
            kind     = 1 - kind;
            k++;
            n_acc++;
         end else if (phase == 2) begin
            phase = 3;
         end else begin
            phase = 0;
         end
         check_eq("stream_resp_valid", bus.resp_valid, (phase == 1 || phase == 3) ? 1'b1 : 1'b0);
         check_eq("stream_wr_en", ram_wr_en, (phase == 1) ? 4'b1111 : 4'b0000);
         check_eq("stream_rd_en", ram_rd_en, (phase == 2) ? 1'b1 : 1'b0);
         if (phase == 1) check_eq("stream_wr_addr", ram_wr_addr, act_addr);
         if (phase == 2) check_eq("stream_rd_addr", ram_rd_addr, act_addr);
         if (phase == 3) check_eq("stream_rdata", bus.resp_rdata, 32'h5A5A_C3C3);
         if (bus.resp_valid === 1'b1) n_resp++;
      end
      bus.req_valid = 1'b0;
      // Drain whatever is still in flight, then every acceptance must have one response.
      for (int cyc = 0; cyc < 3; cyc++) begin
         tick();
         if (bus.resp_valid === 1'b1) n_resp++;
      end
      check_eq("stream_resp_count", 32'(n_resp), 32'(n_acc));
      check_eq("stream_acc_count", 32'(n_acc), 32'd8);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data/address width; only 32 supported.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have ports req_valid input 1, req_ready output 1: request handshake, transfer when both high at a clk edge.
REQ-005 SHALL have ports req_we input 1 (1=store), req_funct3 input 3 (RV32I load/store funct3), req_addr input WIDTH, req_wdata input WIDTH.
REQ-006 SHALL have ports resp_valid output 1 (one-cycle pulse), resp_rdata output WIDTH (extended load data), resp_err output 1 (misaligned/illegal).
REQ-007 SHALL have RAM-side ports ram_wr_en output 4 (byte strobes), ram_wr_addr output WIDTH, ram_wr_data output WIDTH, ram_rd_en output 1, ram_rd_addr output WIDTH, ram_rd_data input WIDTH (valid one cycle after ram_rd_en).

Function
REQ-008 SHALL implement FSM states IDLE, WR, RD, RESP, ERR.
REQ-009 SHALL drive req_ready=1 only in IDLE with rst low; no new request accepted in any other state.
REQ-010 SHALL, on acceptance in IDLE, register we, funct3, addr, wdata and go to ERR if illegal or misaligned, else WR (store) or RD (load).
REQ-011 SHALL treat as illegal: load funct3 011/110/111; store funct3 with bit2=1 or 011.
REQ-012 SHALL treat as misaligned: half-word with addr[0]=1; word with addr[1:0]!=0; bytes never misaligned.
REQ-013 SHALL, in WR (one cycle), drive ram_wr_en = SB 4'b0001<<addr[1:0], SH 4'b0011<<addr[1:0], SW 4'b1111; ram_wr_addr=addr; ram_wr_data = SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata; assert resp_valid=1, resp_err=0, resp_rdata=0; then IDLE.
REQ-014 SHALL, in RD (one cycle), assert ram_rd_en=1, ram_rd_addr=addr, then RESP.
REQ-015 SHALL, in RESP (one cycle), assert resp_valid=1, resp_err=0, resp_rdata from ram_rd_data: byte lane addr[1:0] (LB sign-, LBU zero-extended), half lane addr[1] (LH sign-, LHU zero-extended), LW full word; then IDLE.
REQ-016 SHALL, in ERR (one cycle), assert resp_valid=1, resp_err=1, resp_rdata=0, with no RAM strobe; then IDLE.
REQ-017 SHALL hold ram_wr_en=0 outside WR and ram_rd_en=0 outside RD; addr/data outputs 0 when not strobed.
REQ-018 SHALL give latency acceptance->resp_valid of 1 cycle for stores/errors, 2 cycles for loads; back-to-back issue rate one request per 2 (store/err) or 3 (load) cycles.
REQ-019 SHALL apply no backpressure on responses; consumer always accepts resp_valid.
REQ-020 SHALL ignore req_* inputs when req_ready=0 (no capture, no side effect).

Reset
REQ-021 SHALL, while rst=1 at a clk edge, enter IDLE and clear all captured registers.
REQ-022 SHALL hold all outputs 0 (req_ready included) while rst=1; req_ready=1 first cycle after rst falls.
REQ-023 SHALL abandon any in-flight request on reset: no resp_valid and no RAM strobe in the cycle after the reset edge.

Verification
REQ-024 SW addr 0x100 wdata 0xDEADBEEF -> next cycle ram_wr_en=1111, ram_wr_addr=0x100, ram_wr_data=0xDEADBEEF, resp_valid=1, resp_err=0.
REQ-025 SB addr 0x103 wdata 0x000000A5 -> ram_wr_en=1000, ram_wr_data=0xA5A5A5A5; SH addr 0x102 wdata 0x1234 -> ram_wr_en=1100, ram_wr_data=0x12341234.
REQ-026 LB addr 0x201 with ram_rd_data=0x0000F000 -> ram_rd_en at T+1, resp_rdata=0xFFFFFFF0 at T+2; LBU same -> 0x000000F0; LHU addr 0x202 with ram_rd_data=0x80010000 -> 0x00008001.
REQ-027 LW addr 0x102, SH addr 0x101, load funct3 011 -> each: resp_valid=1, resp_err=1, resp_rdata=0 at T+1, ram_wr_en=0, ram_rd_en=0 throughout.
REQ-028 req_valid held high with alternating SW/LW -> req_ready low in WR/RD/RESP, exactly one response per accepted request, no requests lost or duplicated.
REQ-029 rst asserted in RD cycle of LW -> no resp_valid, ram_rd_en=0 after edge, req_ready=1 the cycle after rst deasserts.
